alu_div_sequencer: RTL

Multi-cycle unsigned 64-bit divider that drives the datapath ALU through its operand and control interface, rather than carrying its own subtractor. It implements restoring division, one quotient bit per clock. It issues subtract (ALUctrl 4'b0110) and uses the returned result and carry-out (borrow) to decide each bit. It sits beside the ALU in the execute stage and owns the ALU operand/control inputs while busy.

---
 rtl/alu_div_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_div_sequencer.sv
// ============================================================================
//  Module   : alu_div_sequencer
//  Purpose  : Multi-cycle unsigned restoring divider that borrows the shared
//             datapath ALU for its trial subtractions, one quotient bit/clock.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_div_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] aluA,
    output logic [WIDTH-1:0] aluB,
    output logic [3:0]       aluCtrl,
    input  logic [WIDTH-1:0] aluRes,
    input  logic             aluC
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [3:0] c_ALU_NOP = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_r;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_last;
    logic             w_top;
    logic [WIDTH-1:0] w_rs;
    logic             w_qbit;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_q_next;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_div_zero = (divisor == '0);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // Shift the next dividend bit into the partial remainder; the bit pushed
    // out of the top means the true value already exceeds any divisor.
    assign w_top    = r_r[WIDTH-1];
    assign w_rs     = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_qbit   = w_top | ~aluC;
    assign w_r_next = w_qbit ? aluRes : w_rs;
    assign w_q_next = {r_q[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_div_zero ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next_state = S_FIN;
                end
            end
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        aluA    = '0;
        aluB    = '0;
        aluCtrl = c_ALU_NOP;
        case (r_state)
            S_CALC: begin
                busy    = 1'b1;
                aluA    = w_rs;
                aluB    = r_d;
                aluCtrl = c_ALU_SUB;
            end
            S_FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_d    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_q   <= dividend;
            r_d   <= divisor;
            r_r   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
            if (w_div_zero) begin
                r_quot <= '1;
                r_rem  <= dividend;
                r_dbz  <= 1'b1;
            end
        end else if (r_state == S_CALC) begin
            r_r   <= w_r_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_quot <= w_q_next;
                r_rem  <= w_r_next;
            end
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire
